// File: rtl/block_positions_pipe.sv
// Two-stage visibility/depth stage for the N nearest blocks.
// Stage 1 classifies each slot against song time, stage 2 produces z and the visible count.
module block_positions_lane #(
  parameter int TIME_WIDTH = 18,
  parameter int ID_WIDTH   = 8,
  parameter int Z_WIDTH    = 14,
  parameter int WINDOW     = 150,
  parameter int Z_SCALE    = 20,
  parameter int Z_FAR      = 3000
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  en_i,
  input  logic                  ld_i,
  input  logic [TIME_WIDTH-1:0] now_i,
  input  logic [TIME_WIDTH-1:0] t_i,
  input  logic [ID_WIDTH-1:0]   id_i,
  output logic                  vis1_o,
  output logic                  vis_o,
  output logic                  exp_o,
  output logic [Z_WIDTH-1:0]    z_o
);
  localparam int DW = $clog2(WINDOW + 1);

  logic [TIME_WIDTH:0]   now_w, t_w, lim_w;
  logic                  vis_d, exp_d;
  logic [DW-1:0]         dist_d;
  logic                  prev_vis_q;
  logic [ID_WIDTH-1:0]   prev_id_q;
  logic                  vis1_q, exp1_q;
  logic [DW-1:0]         dist1_q;
  logic [31:0]           prod;
  logic [Z_WIDTH-1:0]    z_d;
  logic                  vis_q, exp_q;
  logic [Z_WIDTH-1:0]    z_q;

  // One extra bit so now+WINDOW never wraps near the top of song time.
  always_comb begin
    now_w  = {1'b0, now_i};
    t_w    = {1'b0, t_i};
    lim_w  = now_w + (TIME_WIDTH+1)'(WINDOW);
    vis_d  = (t_w > now_w) && (t_w <= lim_w);
    exp_d  = prev_vis_q && (prev_id_q == id_i) && (t_w <= now_w);
    dist_d = DW'(lim_w - t_w);
  end

  // dist = WINDOW - delta; only meaningful (0..WINDOW-1) for visible slots.
  always_comb begin
    prod = 32'(dist1_q) * 32'(Z_SCALE);
    z_d  = vis1_q ? Z_WIDTH'(32'(Z_FAR) - prod) : '0;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      prev_vis_q <= 1'b0;
      prev_id_q  <= '0;
      vis1_q     <= 1'b0;
      exp1_q     <= 1'b0;
      dist1_q    <= '0;
      vis_q      <= 1'b0;
      exp_q      <= 1'b0;
      z_q        <= '0;
    end else begin
      if (ld_i) begin
        prev_vis_q <= vis_d;
        prev_id_q  <= id_i;
        vis1_q     <= vis_d;
        exp1_q     <= exp_d;
        dist1_q    <= dist_d;
      end
      if (en_i) begin
        vis_q <= vis1_q;
        exp_q <= exp1_q;
        z_q   <= z_d;
      end
    end
  end

  assign vis1_o = vis1_q;
  assign vis_o  = vis_q;
  assign exp_o  = exp_q;
  assign z_o    = z_q;
endmodule

module block_positions_pipe #(
  parameter int NUM_BLOCKS  = 12,
  parameter int TIME_WIDTH  = 18,
  parameter int COORD_WIDTH = 12,
  parameter int ID_WIDTH    = 8,
  parameter int Z_WIDTH     = 14,
  parameter int WINDOW      = 150,
  parameter int Z_SCALE     = 20,
  parameter int Z_FAR       = 3000
) (
  input  logic                                    clk_in,
  input  logic                                    rst_in,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [TIME_WIDTH-1:0]                   curr_time_in,
  input  logic [NUM_BLOCKS-1:0][COORD_WIDTH-1:0]  block_x_in,
  input  logic [NUM_BLOCKS-1:0][COORD_WIDTH-1:0]  block_y_in,
  input  logic [NUM_BLOCKS-1:0][TIME_WIDTH-1:0]   block_time_in,
  input  logic [NUM_BLOCKS-1:0]                   block_color_in,
  input  logic [NUM_BLOCKS-1:0][2:0]              block_direction_in,
  input  logic [NUM_BLOCKS-1:0][ID_WIDTH-1:0]     block_ID_in,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [TIME_WIDTH-1:0]                   curr_time_out,
  output logic [NUM_BLOCKS-1:0][COORD_WIDTH-1:0]  block_x_out,
  output logic [NUM_BLOCKS-1:0][COORD_WIDTH-1:0]  block_y_out,
  output logic [NUM_BLOCKS-1:0]                   block_color_out,
  output logic [NUM_BLOCKS-1:0][2:0]              block_direction_out,
  output logic [NUM_BLOCKS-1:0][ID_WIDTH-1:0]     block_ID_out,
  output logic [NUM_BLOCKS-1:0][Z_WIDTH-1:0]      block_z_out,
  output logic [NUM_BLOCKS-1:0]                   block_visible_out,
  output logic [NUM_BLOCKS-1:0]                   block_expired_out,
  output logic [$clog2(NUM_BLOCKS+1)-1:0]         visible_count_out
);
  localparam int STAGES = 2;
  localparam int CW     = $clog2(NUM_BLOCKS + 1);

  logic [STAGES:1]                        vld_pipe_q;
  logic                                   en, ld;
  logic [NUM_BLOCKS-1:0]                  vis1;
  logic [CW-1:0]                          cnt_d, cnt_q;
  logic [TIME_WIDTH-1:0]                  time1_q, time2_q;
  logic [NUM_BLOCKS-1:0][COORD_WIDTH-1:0] x1_q, x2_q, y1_q, y2_q;
  logic [NUM_BLOCKS-1:0]                  col1_q, col2_q;
  logic [NUM_BLOCKS-1:0][2:0]             dir1_q, dir2_q;
  logic [NUM_BLOCKS-1:0][ID_WIDTH-1:0]    id1_q, id2_q;

  // Whole pipe stalls together on downstream backpressure.
  assign en       = !vld_pipe_q[STAGES] || out_ready;
  assign ld       = en && in_valid;
  assign in_ready = en;

  for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_lane
    block_positions_lane #(
      .TIME_WIDTH(TIME_WIDTH), .ID_WIDTH(ID_WIDTH), .Z_WIDTH(Z_WIDTH),
      .WINDOW(WINDOW), .Z_SCALE(Z_SCALE), .Z_FAR(Z_FAR)
    ) u_lane (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .en_i   (en),
      .ld_i   (ld),
      .now_i  (curr_time_in),
      .t_i    (block_time_in[i]),
      .id_i   (block_ID_in[i]),
      .vis1_o (vis1[i]),
      .vis_o  (block_visible_out[i]),
      .exp_o  (block_expired_out[i]),
      .z_o    (block_z_out[i])
    );
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) cnt_d = cnt_d + CW'(vis1[i]);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      vld_pipe_q <= '0;
      cnt_q      <= '0;
      time1_q    <= '0;  time2_q <= '0;
      x1_q       <= '0;  x2_q    <= '0;
      y1_q       <= '0;  y2_q    <= '0;
      col1_q     <= '0;  col2_q  <= '0;
      dir1_q     <= '0;  dir2_q  <= '0;
      id1_q      <= '0;  id2_q   <= '0;
    end else begin
      if (ld) begin
        time1_q <= curr_time_in;
        x1_q    <= block_x_in;
        y1_q    <= block_y_in;
        col1_q  <= block_color_in;
        dir1_q  <= block_direction_in;
        id1_q   <= block_ID_in;
      end
      if (en) begin
        vld_pipe_q <= {vld_pipe_q[STAGES-1:1], in_valid};
        cnt_q      <= cnt_d;
        time2_q    <= time1_q;
        x2_q       <= x1_q;
        y2_q       <= y1_q;
        col2_q     <= col1_q;
        dir2_q     <= dir1_q;
        id2_q      <= id1_q;
      end
    end
  end

  assign out_valid           = vld_pipe_q[STAGES];
  assign visible_count_out   = cnt_q;
  assign curr_time_out       = time2_q;
  assign block_x_out         = x2_q;
  assign block_y_out         = y2_q;
  assign block_color_out     = col2_q;
  assign block_direction_out = dir2_q;
  assign block_ID_out        = id2_q;
endmodule

// File: tb/tb_block_positions_pipe.sv
// Bench for block_positions_pipe: directed boundary steps plus a randomized sweep
// checked against a queue-based reference model of the visibility/expire rules.
module tb_block_positions_pipe;
  localparam int N = 12, TW = 18, XW = 12, IW = 8, ZW = 14;
  localparam int WIN = 150, ZS = 20, ZF = 3000, CNTW = 4;

  logic                   clk_in = 1'b0, rst_in = 1'b1;
  logic                   in_valid, in_ready, out_valid, out_ready;
  logic [TW-1:0]          curr_time_in, curr_time_out;
  logic [N-1:0][XW-1:0]   block_x_in, block_y_in, block_x_out, block_y_out;
  logic [N-1:0][TW-1:0]   block_time_in;
  logic [N-1:0]           block_color_in, block_color_out;
  logic [N-1:0][2:0]      block_direction_in, block_direction_out;
  logic [N-1:0][IW-1:0]   block_ID_in, block_ID_out;
  logic [N-1:0][ZW-1:0]   block_z_out;
  logic [N-1:0]           block_visible_out, block_expired_out;
  logic [CNTW-1:0]        visible_count_out;

  always #5 clk_in = ~clk_in;

  block_positions_pipe dut (
    .clk_in(clk_in), .rst_in(rst_in), .in_valid(in_valid), .in_ready(in_ready),
    .curr_time_in(curr_time_in), .block_x_in(block_x_in), .block_y_in(block_y_in),
    .block_time_in(block_time_in), .block_color_in(block_color_in),
    .block_direction_in(block_direction_in), .block_ID_in(block_ID_in),
    .out_valid(out_valid), .out_ready(out_ready), .curr_time_out(curr_time_out),
    .block_x_out(block_x_out), .block_y_out(block_y_out), .block_color_out(block_color_out),
    .block_direction_out(block_direction_out), .block_ID_out(block_ID_out),
    .block_z_out(block_z_out), .block_visible_out(block_visible_out),
    .block_expired_out(block_expired_out), .visible_count_out(visible_count_out)
  );

  typedef struct {
    logic [TW-1:0]        now;
    logic [N-1:0][TW-1:0] t;
    logic [N-1:0][XW-1:0] x, y;
    logic [N-1:0]         color;
    logic [N-1:0][2:0]    dir;
    logic [N-1:0][IW-1:0] id;
  } snap_t;

  typedef struct {
    snap_t                s;
    logic [N-1:0][ZW-1:0] z;
    logic [N-1:0]         vis, expd;
    logic [CNTW-1:0]      cnt;
  } exp_t;

  exp_t          q[$];
  bit            m_pv[N];
  logic [IW-1:0] m_pid[N];
  int            n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  function automatic snap_t blank(input int now);
    snap_t s;
    s.now = TW'(now);
    for (int i = 0; i < N; i++) begin
      s.t[i]     = '0;
      s.x[i]     = XW'($urandom);
      s.y[i]     = XW'($urandom);
      s.color[i] = 1'($urandom);
      s.dir[i]   = 3'($urandom);
      s.id[i]    = IW'($urandom);
    end
    return s;
  endfunction

  // Reference: delta in plain integers, z from the distance to the hit time.
  function automatic exp_t model(input snap_t s);
    exp_t e;
    int   d, c;
    c = 0;
    e.s = s;
    for (int i = 0; i < N; i++) begin
      d         = int'(s.t[i]) - int'(s.now);
      e.vis[i]  = (d > 0) && (d <= WIN);
      e.z[i]    = e.vis[i] ? ZW'(ZF - ZS * (WIN - d)) : '0;
      e.expd[i] = m_pv[i] && (m_pid[i] == s.id[i]) && (d <= 0);
      if (e.vis[i]) c++;
    end
    e.cnt = CNTW'(c);
    return e;
  endfunction

  task automatic drive(input snap_t s);
    curr_time_in       = s.now;
    block_time_in      = s.t;
    block_x_in         = s.x;
    block_y_in         = s.y;
    block_color_in     = s.color;
    block_direction_in = s.dir;
    block_ID_in        = s.id;
  endtask

  // One clock: drive, check the visible output against the model queue, record acceptance.
  task automatic cycle(input bit iv, input bit ordy, input snap_t s, output bit acc);
    exp_t e;
    in_valid  = iv;
    out_ready = ordy;
    drive(s);
    #1;
    acc = iv && in_ready;
    if (out_valid) begin
      if (q.size() == 0) chk("spurious_out_valid", out_valid, 0);
      else begin
        chk("time", curr_time_out, q[0].s.now);
        chk("x", block_x_out, q[0].s.x);
        chk("y", block_y_out, q[0].s.y);
        chk("color", block_color_out, q[0].s.color);
        chk("dir", block_direction_out, q[0].s.dir);
        chk("id", block_ID_out, q[0].s.id);
        chk("z", block_z_out, q[0].z);
        chk("visible", block_visible_out, q[0].vis);
        chk("expired", block_expired_out, q[0].expd);
        chk("count", visible_count_out, q[0].cnt);
        if (ordy) void'(q.pop_front());
      end
    end
    if (acc) begin
      e = model(s);
      q.push_back(e);
      for (int i = 0; i < N; i++) begin
        m_pv[i]  = e.vis[i];
        m_pid[i] = s.id[i];
      end
    end
    @(posedge clk_in); #1;
  endtask

  initial begin
    snap_t         s, s2;
    bit            acc;
    int            now;
    logic [IW-1:0] gid[N];
    int            gt[N];

    for (int i = 0; i < N; i++) begin m_pv[i] = 0; m_pid[i] = '0; end
    in_valid = 0; out_ready = 0;
    drive(blank(0));
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_z", block_z_out, 0);
    chk("rst_visible", block_visible_out, 0);
    chk("rst_expired", block_expired_out, 0);
    chk("rst_count", visible_count_out, 0);
    chk("rst_time", curr_time_out, 0);
    #9 rst_in = 0;
    @(posedge clk_in); #1;

    // Basic window classification and latency
    s = blank(1000);
    s.t[0] = 1001; s.t[1] = 1150; s.t[2] = 1151; s.t[3] = 1000; s.t[4] = 900;
    cycle(1, 1, s, acc);
    chk("t1_accept", acc, 1);
    chk("t1_valid_after_1", out_valid, 0);
    cycle(0, 1, s, acc);
    chk("t1_valid_after_2", out_valid, 1);
    chk("t1_z0", block_z_out[0], 20);
    chk("t1_z1", block_z_out[1], 3000);
    chk("t1_z2", block_z_out[2], 0);
    chk("t1_z3", block_z_out[3], 0);
    chk("t1_z4", block_z_out[4], 0);
    chk("t1_vis", block_visible_out[4:0], 5'b00011);
    chk("t1_cnt", visible_count_out, 2);

    // Expire on same ID, no expire on ID change
    s = blank(1099); s.t[0] = 1100; s.id[0] = 8'd7;
    cycle(1, 1, s, acc);
    s.now = 1100;
    cycle(1, 1, s, acc);
    cycle(0, 1, s, acc);
    chk("t2_expired_same_id", block_expired_out[0], 1);
    chk("t2_invisible_at_now", block_visible_out[0], 0);
    chk("t2_z_at_now", block_z_out[0], 0);
    s = blank(1099); s.t[0] = 1100; s.id[0] = 8'd7;
    cycle(1, 1, s, acc);
    s.now = 1100; s.id[0] = 8'd8;
    cycle(1, 1, s, acc);
    cycle(0, 1, s, acc);
    chk("t2_no_expire_id_change", block_expired_out[0], 0);

    // Backpressure: full pipe held for 5 cycles, then drained in order
    s = blank(2000);
    for (int i = 0; i < N; i++) s.t[i] = TW'(2000 + i * 13);
    cycle(1, 1, s, acc);
    s2 = blank(2001);
    for (int i = 0; i < N; i++) s2.t[i] = TW'(2001 + i * 17);
    cycle(1, 1, s2, acc);
    s = blank(2002);
    for (int i = 0; i < N; i++) s.t[i] = TW'(2000 + i * 11);
    repeat (5) begin
      cycle(1, 0, s, acc);
      chk("stall_in_ready", in_ready, 0);
    end
    cycle(1, 1, s, acc);
    chk("release_accept", acc, 1);
    repeat (3) cycle(0, 1, s, acc);
    chk("drain_queue_empty", q.size(), 0);
    chk("drain_out_valid", out_valid, 0);

    // No wrap of now+WINDOW near the top of song time
    s = blank((1 << TW) - 10); s.t[0] = '1;
    cycle(1, 1, s, acc);
    cycle(0, 1, s, acc);
    chk("wrap_visible", block_visible_out[0], 1);
    chk("wrap_z", block_z_out[0], 180);

    // Async reset mid-stall clears pipe and history
    s = blank(5000); s.t[0] = 5050; s.id[0] = 8'd5;
    cycle(1, 1, s, acc);
    s.now = 5001;
    cycle(1, 0, s, acc);
    cycle(0, 0, s, acc);
    #2 rst_in = 1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_z", block_z_out, 0);
    chk("arst_visible", block_visible_out, 0);
    chk("arst_expired", block_expired_out, 0);
    chk("arst_count", visible_count_out, 0);
    chk("arst_x", block_x_out, 0);
    q.delete();
    for (int i = 0; i < N; i++) begin m_pv[i] = 0; m_pid[i] = '0; end
    #2 rst_in = 0;
    @(posedge clk_in); #1;
    s = blank(5100); s.t[0] = 5050; s.id[0] = 8'd5;
    cycle(1, 1, s, acc);
    cycle(0, 1, s, acc);
    chk("post_rst_no_expire", block_expired_out[0], 0);

    // Randomized sweep with random bubbles and backpressure
    now = 20000;
    for (int i = 0; i < N; i++) begin
      gid[i] = IW'($urandom);
      gt[i]  = now + int'($urandom_range(0, 220)) - 20;
    end
    for (int k = 0; k < 3000; k++) begin
      s = blank(now);
      for (int i = 0; i < N; i++) begin
        s.t[i]  = TW'(gt[i]);
        s.id[i] = gid[i];
      end
      cycle($urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0, s, acc);
      if (acc) begin
        now += int'($urandom_range(0, 4));
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(0, 15) == 0 || gt[i] < now - 10) begin
            gid[i] = ($urandom_range(0, 3) == 0) ? gid[i] : IW'($urandom);
            gt[i]  = now + int'($urandom_range(0, 220)) - 20;
          end
        end
      end
    end
    repeat (4) cycle(0, 1, s, acc);
    chk("final_queue_empty", q.size(), 0);
    chk("final_out_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
